// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and baud helpers for the UART receiver
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;
`endif

    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    function automatic int baud_cnt_width(input int clk_freq, input int uart_bps);
        return $clog2(clk_freq / uart_bps);
    endfunction

endpackage

// File: rtl/uart_rx_sample_gen.sv
// rtl/uart_rx_sample_gen.sv - baud counter, 3-point majority voter and bit strobe
module uart_rx_sample_gen #(
    parameter int BAUD_CNT_MAX = 5208,
    parameter int CNT_W        = 13
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic clr,
    input  logic rx_bit,
    output logic bit_strobe,
    output logic bit_val
);

    localparam int HALF = BAUD_CNT_MAX / 2;

    logic [CNT_W-1:0] baud_cnt;
    logic             samp0;
    logic             samp1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt <= '0;
            samp0    <= 1'b1;
            samp1    <= 1'b1;
        end else begin
            if (clr) begin
                baud_cnt <= '0;
            end else if (en) begin
                baud_cnt <= (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1)) ? '0 : baud_cnt + CNT_W'(1);
            end
            if (en && baud_cnt == CNT_W'(HALF - 1)) samp0 <= rx_bit;
            if (en && baud_cnt == CNT_W'(HALF))     samp1 <= rx_bit;
        end
    end

    // Third sample is the live synchronised bit at the strobe count itself.
    assign bit_strobe = en && (baud_cnt == CNT_W'(HALF + 1));
    assign bit_val    = (samp0 & samp1) | (samp0 & rx_bit) | (samp1 & rx_bit);

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - configurable UART receiver with framing/parity checks
// Parity bit and checker are present only when UART_RX_PARITY_EN is defined.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CNT_W        = baud_cnt_width(CLK_FREQ, UART_BPS);

    logic                 rx_sync1;
    logic                 rx_sync2;
    logic                 rx_hist;
    logic                 fall_r;
    logic                 armed;
    logic [1:0]           settle_cnt;

    uart_rx_state_t       state;
    logic [DATA_BITS-1:0] shadow;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic                 frame_acc;
    logic                 start_edge;
    logic                 bit_strobe;
    logic                 bit_val;

    // After reset the synchroniser shows its reset value, not the line, so
    // edges are only armed once a real high level has been seen.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_sync1   <= 1'b1;
            rx_sync2   <= 1'b1;
            rx_hist    <= 1'b1;
            fall_r     <= 1'b0;
            armed      <= 1'b0;
            settle_cnt <= 2'd0;
        end else begin
            rx_sync1 <= rx;
            rx_sync2 <= rx_sync1;
            rx_hist  <= rx_sync2;
            fall_r   <= armed && !rx_sync2 && rx_hist;
            if (settle_cnt != 2'd3) begin
                settle_cnt <= settle_cnt + 2'd1;
            end else if (rx_sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = (state == IDLE) && fall_r;

    uart_rx_sample_gen #(
        .BAUD_CNT_MAX (BAUD_CNT_MAX),
        .CNT_W        (CNT_W)
    ) u_sample_gen (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .en         (state != IDLE),
        .clr        (start_edge),
        .rx_bit     (rx_sync2),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    logic par_bad;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            bit_idx   <= 3'd0;
            stop_idx  <= 1'b0;
            frame_acc <= 1'b0;
            po_data   <= '0;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            po_flag <= 1'b0;
            rx_busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (start_edge) state <= START;
                end
                START: begin
                    if (bit_strobe) begin
                        bit_idx <= 3'd0;
                        state   <= bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_strobe) begin
                        shadow <= {bit_val, shadow[DATA_BITS-1:1]};
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            stop_idx  <= 1'b0;
                            frame_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_strobe) begin
                        par_bad <= bit_val != ((^shadow) ^ (PARITY_ODD != PARITY_MODE_EVEN));
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_strobe) begin
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            // Leave at mid final stop bit so back-to-back starts are caught.
                            state     <= IDLE;
                            po_flag   <= 1'b1;
                            po_data   <= shadow;
                            frame_err <= frame_acc | ~bit_val;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_bad;
`endif
                        end else begin
                            stop_idx  <= 1'b1;
                            frame_acc <= frame_acc | ~bit_val;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame (8N1 and 7-bit/2-stop instances)
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int CLK_FREQ = 1_600_000;
    localparam int UART_BPS = 100_000;
    localparam int BAUD     = CLK_FREQ / UART_BPS;
    localparam int HALF     = BAUD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx_a      = 1'b1;
    logic       rx_b      = 1'b1;
    logic [7:0] po_data_a;
    logic [6:0] po_data_b;
    logic       po_flag_a, frame_err_a, parity_err_a, rx_busy_a;
    logic       po_flag_b, frame_err_b, parity_err_b, rx_busy_b;

    uart_rx_frame #(
        .UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_a), .po_data(po_data_a),
        .po_flag(po_flag_a), .frame_err(frame_err_a), .parity_err(parity_err_a), .rx_busy(rx_busy_a)
    );

    uart_rx_frame #(
        .UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_b), .po_data(po_data_b),
        .po_flag(po_flag_b), .frame_err(frame_err_b), .parity_err(parity_err_b), .rx_busy(rx_busy_b)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        int         at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (po_flag_a === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_flag", 1, 0);
            end else begin
                ea = qa.pop_front();
                check("a_data", po_data_a, ea.data);
                check("a_frame_err", frame_err_a, ea.fe);
                check("a_parity_err", parity_err_a, ea.pe);
                check("a_flag_cycle", cyc, ea.at);
            end
        end
        if (po_flag_b === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_flag", 1, 0);
            end else begin
                eb = qb.pop_front();
                check("b_data", {1'b0, po_data_b}, eb.data);
                check("b_frame_err", frame_err_b, eb.fe);
                check("b_parity_err", parity_err_b, eb.pe);
                check("b_flag_cycle", cyc, eb.at);
            end
        end
    end

    task automatic drive(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Builds the line waveform from the frame rules, predicts the delivered
    // character and the cycle of its strobe, then plays the waveform out.
    task automatic send(input bit which, input int nd, input int ns, input logic [7:0] d,
                        input logic [1:0] stop_lo, input bit par_flip, input bit glitch);
        logic line[$];
        exp_t e;
        logic par;
        logic v;
        int   nbits;
        par = 1'b0;
        line.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            line.push_back(d[i]);
            par ^= d[i];
        end
        if (PBITS != 0) line.push_back(par ^ par_flip);
        e.fe = 1'b0;
        for (int i = 0; i < ns; i++) begin
            line.push_back(!stop_lo[i]);
            e.fe |= stop_lo[i];
        end
        nbits  = line.size();
        e.data = d & 8'((1 << nd) - 1);
        e.pe   = (PBITS != 0) ? par_flip : 1'b0;
        @(posedge sys_clk);
        #1;
        e.at = cyc + 6 + HALF + (nbits - 1) * BAUD;
        if (which) qb.push_back(e);
        else       qa.push_back(e);
        for (int c = 0; c < nbits * BAUD; c++) begin
            if (c > 0) begin
                @(posedge sys_clk);
                #1;
            end
            v = line[c / BAUD];
            if (glitch && (c % BAUD) == HALF + 2) v = ~v;
            drive(which, v);
        end
        @(posedge sys_clk);
        #1;
        drive(which, 1'b1);
    endtask

    logic [7:0] rd;
    logic [1:0] rstop;
    bit         rwhich, rerr;

    initial begin
        idle(5);
        check("reset_po_flag_a", po_flag_a, 0);
        check("reset_po_data_a", po_data_a, 0);
        check("reset_frame_err_a", frame_err_a, 0);
        check("reset_parity_err_a", parity_err_a, 0);
        check("reset_rx_busy_a", rx_busy_a, 0);
        check("reset_po_data_b", po_data_b, 0);
        sys_rst_n = 1'b1;
        idle(10);

        send(0, 8, 1, 8'h55, 2'b00, 1'b0, 1'b0);
        idle(4);

        rx_a = 1'b0;
        idle(HALF - 3);
        rx_a = 1'b1;
        idle(3 * BAUD);
        check("a_busy_after_false_start", rx_busy_a, 0);
        send(0, 8, 1, 8'hA3, 2'b00, 1'b0, 1'b0);
        idle(3);

        send(0, 8, 1, 8'h3C, 2'b01, 1'b0, 1'b0);
        idle(2);
        send(0, 8, 1, 8'h01, 2'b00, 1'b0, 1'b0);
        idle(3);

`ifdef UART_RX_PARITY_EN
        send(0, 8, 1, 8'hA5, 2'b00, 1'b1, 1'b0);
        send(0, 8, 1, 8'hA5, 2'b00, 1'b0, 1'b0);
        idle(3);
`endif

        send(1, 7, 2, 8'h7F, 2'b00, 1'b0, 1'b1);
        send(1, 7, 2, 8'h00, 2'b00, 1'b0, 1'b1);
        idle(3);

        rx_a = 1'b0;
        idle(5 * BAUD + HALF);
        check("a_busy_mid_frame", rx_busy_a, 1);
        sys_rst_n = 1'b0;
        #1;
        check("midreset_po_data_a", po_data_a, 0);
        check("midreset_po_flag_a", po_flag_a, 0);
        check("midreset_frame_err_a", frame_err_a, 0);
        check("midreset_rx_busy_a", rx_busy_a, 0);
        rx_a = 1'b1;
        idle(5);
        sys_rst_n = 1'b1;
        idle(10);
        send(0, 8, 1, 8'h96, 2'b00, 1'b0, 1'b0);
        idle(3);

        for (int n = 0; n < 24; n++) begin
            rwhich = 1'($urandom_range(0, 1));
            rd     = 8'($urandom);
            rerr   = ($urandom_range(0, 3) == 0);
            rstop  = rerr ? (rwhich ? 2'($urandom_range(1, 3)) : 2'b01) : 2'b00;
            send(rwhich, rwhich ? 7 : 8, rwhich ? 2 : 1, rd, rstop,
                 1'($urandom_range(0, 1)), !rerr && ($urandom_range(0, 1) == 1));
            idle(rerr ? 2 : $urandom_range(0, 4));
        end

        idle(4 * BAUD);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
